captura_digito: RTL and testbench
=================================

# captura_digito

Upstream capture stage for the digit classifier. Watches the raster pixel stream from the video path and downsamples a fixed square window into an 11×11 grid of 8-bit cell averages. Each cell is the mean of a CELL×CELL pixel block. It publishes the complete grid as the `numero` matrix with a one-cycle `flag` pulse. The outputs feed the digit-processing stage (difference, pixel-sum and minimum-distance units) directly.

## Interface
- `ROI_X`, 300: x coordinate of the window's top-left pixel.
- `ROI_Y`, 220: y coordinate of the window's top-left pixel.
- `LOG2_CELL`, 2: log2 of cell edge; CELL = 2^LOG2_CELL. The window is 11·CELL pixels square (44×44 by default).
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `habilita`  in  1  capture enable; sampled only at frame start.
- `pixel_valid`  in  1  qualifies `pixel`, `pixel_x` and `pixel_y` this cycle.
- `pixel_x`  in  10  column of the current pixel; raster order.
- `pixel_y`  in  10  row of the current pixel.
- `pixel`  in  8  grayscale intensity.
- `numero`  out  968  committed grid, flattened. Cell (r,c) is bits `[(r*11+c)*8 +: 8]`; r is the row, c the column, both 0..10.
- `flag`  out  1  one-cycle pulse when `numero` has just been updated.
- `ocupado`  out  1  high while in CAPTURE or COMMIT.

## Operation
- **Frame start:** a cycle with `pixel_valid`=1, `pixel_x`=0 and `pixel_y`=0.
- **In-window pixel:** a valid pixel with ROI_X ≤ x < ROI_X+11·CELL and ROI_Y ≤ y < ROI_Y+11·CELL.
  - Cell column c = (x−ROI_X)>>LOG2_CELL.
  - Cell row r = (y−ROI_Y)>>LOG2_CELL.
  - Pixels outside the window, or with `pixel_valid`=0, are ignored.
- **States:** IDLE, CAPTURE, COMMIT.
  - IDLE → CAPTURE on a frame start with `habilita`=1. Clear all 11 column accumulators and the cell-done counter.
  - CAPTURE, every in-window pixel: acc[c] += pixel. Accumulators are 8+2·LOG2_CELL bits wide (12 bits by default), so they cannot overflow.
  - CAPTURE, pixel at x offset ≡ CELL−1 and y offset ≡ CELL−1 within its cell (the block's last pixel):
    - write staging[r][c] = (acc[c] + pixel) >> (2·LOG2_CELL), truncating;
    - clear acc[c];
    - increment the cell counter.
  - CAPTURE → COMMIT when the counter reaches 121, i.e. cell (10,10) is written.
  - COMMIT: copy staging into `numero`, pulse `flag`, then go to IDLE.
  - CAPTURE, frame start: abort and restart.
    - With `habilita`=1: clear accumulators and counter, stay in CAPTURE. The restart pixel itself is not in-window unless ROI is at 0,0.
    - With `habilita`=0: go to IDLE.
    - Staging contents are don't-care after an abort. `numero` is untouched and no `flag` is produced.
- **Double buffering:** `numero` changes only in COMMIT, so the downstream combinational stage always sees a stable, complete grid.
- `habilita` deasserted mid-capture has no effect until the next frame start.

## Timing
- **Reset values:** `numero`=0 (all 968 bits), `flag`=0, `ocupado`=0, state IDLE, accumulators and counter 0.
- **Reset mid-capture:** everything returns to reset values immediately (asynchronous); a partial grid is never published.
- **Latency:**
  - Cycle N: last window pixel (ROI_X+11·CELL−1, ROI_Y+11·CELL−1) accepted.
  - Cycle N+1: staging[10][10] written, state = COMMIT.
  - Cycle N+2: new `numero` visible and `flag`=1 for that cycle only.
  - `ocupado` falls in cycle N+3.
- **Throughput:** one pixel per cycle; arbitrary `pixel_valid` gaps are allowed. Cell closure uses coordinates, not cycle counts.
- **Simultaneous events:** a frame start in cycle N+1 (COMMIT) is ignored; commit completes. The earliest new capture begins at the next frame start.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then one full frame with `habilita`=1 and every pixel = 100 → all 121 cells = 100. `flag` pulses exactly once, 2 cycles after pixel (343,263).
- Pixel value = 10·r+c inside cell (r,c), 255 everywhere outside the window → cell (r,c) = 10r+c. Confirms outside pixels are ignored and the flattened index mapping.
- Truncation: one cell holding fifteen 1s and one 2 (sum 17) → 1. A cell of all 255 (sum 4080) → 255; no overflow.
- Abort: second frame start while `pixel_y`=250, then no completion → no `flag`; `numero` keeps the previous frame's grid.
- Random `pixel_valid` gaps (~50% duty) on the uniform-100 frame → same result as the gapless run.
- Assert `reset` mid-capture, then release → `numero`=0. The next full frame commits normally; `habilita`=0 at frame start yields no capture.

Source files
------------

// File: rtl/captura_digito.sv
// captura_digito: averages an 11x11 grid of CELLxCELL pixel blocks taken from a fixed window of the raster stream.
// Latency: the new grid and a one-cycle flag appear two cycles after the window's last pixel is accepted.
// No backpressure: one pixel per cycle, any pixel_valid gaps; numero only changes in COMMIT (double buffered).
module captura_digito #(
  parameter int ROI_X     = 300,
  parameter int ROI_Y     = 220,
  parameter int LOG2_CELL = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         habilita,
  input  logic         pixel_valid,
  input  logic [9:0]   pixel_x,
  input  logic [9:0]   pixel_y,
  input  logic [7:0]   pixel,
  output logic [967:0] numero,
  output logic         flag,
  output logic         ocupado
);

  localparam int GRID  = 11;
  localparam int CELLS = GRID * GRID;
  localparam int ACC_W = 8 + 2 * LOG2_CELL;
  localparam int WIN   = GRID << LOG2_CELL;

  // 11-bit bounds so the window's upper edge can never wrap against the 10-bit coordinates
  localparam logic [10:0] X_LO = 11'(ROI_X);
  localparam logic [10:0] X_HI = 11'(ROI_X + WIN);
  localparam logic [10:0] Y_LO = 11'(ROI_Y);
  localparam logic [10:0] Y_HI = 11'(ROI_Y + WIN);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc [0:GRID-1];
  logic [6:0]         cnt;
  logic [967:0]       staging;

  logic [10:0]        px_w, py_w, dx, dy;
  logic               in_win, frame_start, cell_end;
  logic [3:0]         col, row;
  logic [6:0]         cell_idx;
  logic [ACC_W-1:0]   acc_sum;
  logic [7:0]         cell_avg;

  // Decode the current pixel: window membership, cell coordinates, and the running block sum
  always_comb begin
    px_w        = {1'b0, pixel_x};
    py_w        = {1'b0, pixel_y};
    dx          = px_w - X_LO;
    dy          = py_w - Y_LO;
    frame_start = pixel_valid && (pixel_x == 10'd0) && (pixel_y == 10'd0);
    in_win      = pixel_valid && (px_w >= X_LO) && (px_w < X_HI) &&
                  (py_w >= Y_LO) && (py_w < Y_HI);
    col         = dx[LOG2_CELL +: 4];
    row         = dy[LOG2_CELL +: 4];
    // the block's bottom-right pixel closes the cell
    cell_end    = (&dx[LOG2_CELL-1:0]) && (&dy[LOG2_CELL-1:0]);
    cell_idx    = {3'b000, row} * 7'd11 + {3'b000, col};
    acc_sum     = acc[col] + ACC_W'(pixel);
    // dividing by CELL*CELL is just keeping the top 8 bits of the sum
    cell_avg    = acc_sum[ACC_W-1 -: 8];
  end

  // Capture FSM: column accumulators, staging grid, and the registered published grid/flag/busy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      staging <= '0;
      numero  <= '0;
      flag    <= 1'b0;
      ocupado <= 1'b0;
      for (int i = 0; i < GRID; i++) acc[i] <= '0;
    end else begin
      flag    <= 1'b0;
      // busy mirrors the previous cycle's state, so it stays up through the flag cycle
      ocupado <= (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_start && habilita) begin
            state <= CAPTURE;
            cnt   <= '0;
            for (int i = 0; i < GRID; i++) acc[i] <= '0;
            // only reachable when the window sits at the origin
            if (in_win) acc[col] <= ACC_W'(pixel);
          end
        end
        CAPTURE: begin
          if (frame_start) begin
            // a new frame aborts the partial grid; numero is left alone
            cnt <= '0;
            for (int i = 0; i < GRID; i++) acc[i] <= '0;
            if (!habilita) begin
              state <= IDLE;
            end else if (in_win) begin
              acc[col] <= ACC_W'(pixel);
            end
          end else if (in_win) begin
            if (cell_end) begin
              staging[{cell_idx, 3'b000} +: 8] <= cell_avg;
              acc[col] <= '0;
              cnt      <= cnt + 7'd1;
              if (cnt == 7'(CELLS - 1)) state <= COMMIT;
            end else begin
              acc[col] <= acc_sum;
            end
          end
        end
        COMMIT: begin
          // frame starts seen here are deliberately dropped
          numero <= staging;
          flag   <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_captura_digito.sv
// Directed bench for captura_digito: uniform, indexed and truncation frames,
// abort, pixel_valid gaps, asynchronous reset mid-capture and disabled capture.
module tb_captura_digito;

  localparam int RX = 300;
  localparam int RY = 220;

  logic         clock;
  logic         reset;
  logic         habilita;
  logic         pixel_valid;
  logic [9:0]   pixel_x;
  logic [9:0]   pixel_y;
  logic [7:0]   pixel;
  logic [967:0] numero;
  logic         flag;
  logic         ocupado;

  int total = 0;
  int bad   = 0;
  int flag_cnt = 0;

  captura_digito #(.ROI_X(RX), .ROI_Y(RY), .LOG2_CELL(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .pixel_valid (pixel_valid),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel       (pixel),
    .numero      (numero),
    .flag        (flag),
    .ocupado     (ocupado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) if (flag === 1'b1) flag_cnt++;

  task automatic check(input string tag, input logic [967:0] got, input logic [967:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stimulus pixel value for a given pattern at absolute (x,y)
  function automatic logic [7:0] pix_val(input int mode, input int x, input int y);
    int dx, dy, r, c;
    bit inw;
    dx  = x - RX;
    dy  = y - RY;
    inw = (dx >= 0) && (dx < 44) && (dy >= 0) && (dy < 44);
    r   = dy / 4;
    c   = dx / 4;
    if (mode == 0) return 8'd100;
    if (!inw) return 8'd255;
    if (mode == 1) return 8'(10 * r + c);
    if (r == 0 && c == 0) return ((dx % 4 == 0) && (dy % 4 == 0)) ? 8'd2 : 8'd1;
    if (r == 0 && c == 1) return 8'd255;
    return 8'((dx % 4) * 4 + (dy % 4));
  endfunction

  // Hand-derived cell averages for each pattern
  function automatic logic [967:0] exp_grid(input int mode);
    logic [967:0] g;
    logic [7:0]   v;
    g = '0;
    for (int r = 0; r < 11; r++) begin
      for (int c = 0; c < 11; c++) begin
        if (mode == 0)                v = 8'd100;
        else if (mode == 1)           v = 8'(10 * r + c);
        else if (r == 0 && c == 0)    v = 8'd1;    // 17/16 truncates
        else if (r == 0 && c == 1)    v = 8'd255;  // 4080/16
        else                          v = 8'd7;    // 120/16 truncates
        g[(r * 11 + c) * 8 +: 8] = v;
      end
    end
    return g;
  endfunction

  task automatic drive(input bit v, input int x, input int y, input logic [7:0] p);
    pixel_valid = v;
    pixel_x     = 10'(x);
    pixel_y     = 10'(y);
    pixel       = p;
    @(posedge clock);
    #1;
    pixel_valid = 1'b0;
  endtask

  // Frame start, then the window plus a one-pixel border, stopping before row stop_y
  task automatic run_frame(input int mode, input bit hab, input bit gaps, input int stop_y);
    habilita = hab;
    drive(1'b1, 0, 0, 8'd55);
    habilita = 1'b0;
    for (int y = RY - 1; y <= RY + 43; y++) begin
      if (y >= stop_y) break;
      for (int x = RX - 1; x <= RX + 44; x++) begin
        if (y == RY + 43 && x == RX + 44) break;
        if (gaps && ($urandom_range(0, 1) == 1)) drive(1'b0, RX + 43, RY + 43, 8'd0);
        drive(1'b1, x, y, pix_val(mode, x, y));
      end
    end
  endtask

  // Called in the cycle after the window's last pixel
  task automatic finish_check(input int mode);
    check("n1_flag", 968'(flag), 968'(0));
    check("n1_ocupado", 968'(ocupado), 968'(1));
    @(posedge clock); #1;
    check("n2_flag", 968'(flag), 968'(1));
    check("n2_numero", numero, exp_grid(mode));
    @(posedge clock); #1;
    check("n3_flag", 968'(flag), 968'(0));
    check("n3_ocupado", 968'(ocupado), 968'(0));
  endtask

  initial begin
    reset = 1'b1; habilita = 1'b0; pixel_valid = 1'b0;
    pixel_x = '0; pixel_y = '0; pixel = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_numero", numero, '0);
    check("rst_flag", 968'(flag), 968'(0));
    check("rst_ocupado", 968'(ocupado), 968'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    // Uniform 100, with a frame start offered during COMMIT that must be ignored
    run_frame(0, 1'b1, 1'b0, 1023);
    check("a_n1_flag", 968'(flag), 968'(0));
    check("a_n1_ocupado", 968'(ocupado), 968'(1));
    habilita = 1'b1;
    drive(1'b1, 0, 0, 8'd0);
    habilita = 1'b0;
    check("a_n2_flag", 968'(flag), 968'(1));
    check("a_n2_ocupado", 968'(ocupado), 968'(1));
    check("a_n2_numero", numero, exp_grid(0));
    @(posedge clock); #1;
    check("a_n3_flag", 968'(flag), 968'(0));
    check("a_n3_ocupado", 968'(ocupado), 968'(0));
    @(posedge clock); #1;
    check("a_n4_ocupado", 968'(ocupado), 968'(0));
    check("a_flag_count", 968'(flag_cnt), 968'(1));

    // Indexed pattern with 255 border
    run_frame(1, 1'b1, 1'b0, 1023);
    finish_check(1);

    // Truncation and full-scale cells
    run_frame(2, 1'b1, 1'b0, 1023);
    finish_check(2);

    // Abort at row 250 with a restart, then drop to idle
    run_frame(1, 1'b1, 1'b0, 250);
    habilita = 1'b1;
    drive(1'b1, 0, 0, 8'd9);
    habilita = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    check("abort_flag_count", 968'(flag_cnt), 968'(3));
    check("abort_numero", numero, exp_grid(2));
    check("abort_ocupado", 968'(ocupado), 968'(1));
    habilita = 1'b0;
    drive(1'b1, 0, 0, 8'd9);
    @(posedge clock); #1;
    check("abort_idle_ocupado", 968'(ocupado), 968'(0));

    // Uniform 100 with random valid gaps
    run_frame(0, 1'b1, 1'b1, 1023);
    finish_check(0);

    // Asynchronous reset mid-capture
    run_frame(1, 1'b1, 1'b0, 240);
    reset = 1'b1;
    #2;
    check("arst_numero", numero, '0);
    check("arst_ocupado", 968'(ocupado), 968'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    run_frame(1, 1'b1, 1'b0, 1023);
    finish_check(1);

    // Frame start with habilita low from idle: no capture
    run_frame(0, 1'b0, 1'b0, 1023);
    repeat (5) @(posedge clock);
    #1;
    check("dis_numero", numero, exp_grid(1));
    check("dis_ocupado", 968'(ocupado), 968'(0));
    check("final_flag_count", 968'(flag_cnt), 968'(5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
